// File: rtl/interval_timer_if.sv
// Timer control/status bundle between the traffic-light FSM (master) and interval_timer (slave).
// busy/time_left exist only when TIMER_STATUS_EN is defined.
interface interval_timer_if #(
    parameter int CNT_W = 4
);
    logic             start_timer;
    logic [1:0]       interval;
    logic             Prog_Sync;
    logic [1:0]       Time_Parameter_Selector;
    logic [CNT_W-1:0] Time_Value;
    logic             expired;
`ifdef TIMER_STATUS_EN
    logic             busy;
    logic [CNT_W-1:0] time_left;

    modport master (
        output start_timer, interval, Prog_Sync, Time_Parameter_Selector, Time_Value,
        input  expired, busy, time_left
    );
    modport slave (
        input  start_timer, interval, Prog_Sync, Time_Parameter_Selector, Time_Value,
        output expired, busy, time_left
    );
`else
    modport master (
        output start_timer, interval, Prog_Sync, Time_Parameter_Selector, Time_Value,
        input  expired
    );
    modport slave (
        input  start_timer, interval, Prog_Sync, Time_Parameter_Selector, Time_Value,
        output expired
    );
`endif
endinterface

// File: rtl/interval_timer.sv
// Programmable seconds countdown; expired pulses the cycle after edge k + T*DIV; no backpressure.
// start_timer always wins over a pending tick. TIMER_STATUS_EN adds busy/time_left outputs.
module interval_timer #(
    parameter int CNT_W  = 4,
    parameter int DIV    = 100,
    parameter int T_BASE = 6,
    parameter int T_EXT  = 3,
    parameter int T_YEL  = 2
) (
    input  logic           clk,
    input  logic           Reset_Sync,
    interval_timer_if.slave tif
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] DEF_BASE = CNT_W'(T_BASE);
    localparam logic [CNT_W-1:0] DEF_EXT  = CNT_W'(T_EXT);
    localparam logic [CNT_W-1:0] DEF_YEL  = CNT_W'(T_YEL);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             expired_q, expired_d;
    logic             tick;
    logic [CNT_W-1:0] base_q, ext_q, yel_q;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] prog_val;

    always_comb begin
        case (tif.interval)
            2'b01:   load_val = ext_q;
            2'b10:   load_val = yel_q;
            default: load_val = base_q;
        endcase
    end

    // Zero is reserved as "restore default", so a parameter can never be 0.
    always_comb begin
        prog_val = tif.Time_Value;
        if (tif.Time_Value == '0) begin
            case (tif.Time_Parameter_Selector)
                2'b01:   prog_val = DEF_EXT;
                2'b10:   prog_val = DEF_YEL;
                default: prog_val = DEF_BASE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Reset_Sync) begin
        if (Reset_Sync) begin
            base_q <= DEF_BASE;
            ext_q  <= DEF_EXT;
            yel_q  <= DEF_YEL;
        end else if (tif.Prog_Sync) begin
            case (tif.Time_Parameter_Selector)
                2'b00:   base_q <= prog_val;
                2'b01:   ext_q  <= prog_val;
                2'b10:   yel_q  <= prog_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Reset_Sync) begin
        if (Reset_Sync) begin
            state_q   <= IDLE;
            count_q   <= '0;
            div_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            div_q     <= div_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        div_d     = div_q;
        expired_d = 1'b0;
        tick      = (state_q == RUN) && (div_q == DIV_W'(DIV - 1));
        if (tif.start_timer) begin
            // A restart silently drops any tick landing on the same edge.
            count_d = load_val;
            div_d   = '0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                if (count_q > CNT_W'(1)) begin
                    count_d = count_q - 1'b1;
                end else begin
                    count_d   = '0;
                    state_d   = IDLE;
                    expired_d = 1'b1;
                end
            end
        end
    end

    assign tif.expired = expired_q;

`ifdef TIMER_STATUS_EN
    assign tif.busy      = (state_q == RUN);
    assign tif.time_left = count_q;
`endif

endmodule

// File: tb/tb_interval_timer.sv
// Scoreboard bench: stimulus pushes the expected expiry cycle, a negedge monitor pops and compares.
module tb_interval_timer;
    localparam int CNT_W = 4;
    localparam int DIV   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    interval_timer_if #(.CNT_W(CNT_W)) tif ();

    interval_timer #(
        .CNT_W(CNT_W), .DIV(DIV), .T_BASE(6), .T_EXT(3), .T_YEL(2)
    ) dut (
        .clk       (clk),
        .Reset_Sync(rst),
        .tif       (tif)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int DEF [3] = '{6, 3, 2};
    int prm [3];
    int q[$];
    int checks = 0;
    int failures = 0;

    // Monitor: expired must appear exactly on the cycle the model predicted.
    always @(negedge clk) begin
        if (tif.expired === 1'b1) begin
            checks++;
            if (q.size() > 0 && q[0] == cyc) begin
                void'(q.pop_front());
            end else begin
                failures++;
                $display("FAIL expired_unexpected cyc=%0d got=1 want=0 next_due=%0d",
                         cyc, (q.size() > 0) ? q[0] : -1);
            end
        end else if (q.size() > 0 && q[0] <= cyc) begin
            checks++;
            failures++;
            $display("FAIL expired_missing cyc=%0d got=%b want=1 due=%0d", cyc, tif.expired, q[0]);
            void'(q.pop_front());
        end
`ifdef TIMER_STATUS_EN
        begin
            logic exp_busy;
            int   exp_tl;
            exp_busy = (q.size() > 0);
            exp_tl   = exp_busy ? (q[0] - cyc + DIV - 1) / DIV : 0;
            checks++;
            if (tif.busy !== exp_busy || int'(tif.time_left) != exp_tl) begin
                failures++;
                $display("FAIL status cyc=%0d got busy=%b left=%0d want busy=%b left=%0d",
                         cyc, tif.busy, tif.time_left, exp_busy, exp_tl);
            end
        end
`endif
    end

    task automatic clear_inputs();
        tif.start_timer             = 1'b0;
        tif.interval                = 2'b00;
        tif.Prog_Sync               = 1'b0;
        tif.Time_Parameter_Selector = 2'b00;
        tif.Time_Value              = '0;
    endtask

    // One cycle of stimulus; the model resolves the load before the program write.
    task automatic step(input logic st, input logic [1:0] iv, input logic pg,
                        input logic [1:0] sel, input int val);
        int idx;
        @(negedge clk);
        #1;
        tif.start_timer             = st;
        tif.interval                = iv;
        tif.Prog_Sync               = pg;
        tif.Time_Parameter_Selector = sel;
        tif.Time_Value              = CNT_W'(val);
        if (st) begin
            idx = (iv == 2'b11) ? 0 : int'(iv);
            q.delete();
            q.push_back(cyc + 1 + prm[idx] * DIV);
        end
        if (pg && sel != 2'b11) prm[sel] = (val == 0) ? DEF[sel] : val;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 2'b00, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        clear_inputs();
        q.delete();
        prm = DEF;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        prm = DEF;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tif.expired !== 1'b0) begin
            failures++;
            $display("FAIL reset_expired got=%b want=0", tif.expired);
        end

        // Default base run
        step(1'b1, 2'b00, 1'b0, 2'b00, 0);
        idle(30);
        // Program yellow, then restore its default
        step(1'b0, 2'b00, 1'b1, 2'b10, 5);
        step(1'b1, 2'b10, 1'b0, 2'b00, 0);
        idle(25);
        step(1'b0, 2'b00, 1'b1, 2'b10, 0);
        step(1'b1, 2'b10, 1'b0, 2'b00, 0);
        idle(12);
        // Restart mid-run
        step(1'b1, 2'b01, 1'b0, 2'b00, 0);
        idle(5);
        step(1'b1, 2'b10, 1'b0, 2'b00, 0);
        idle(12);
        // Restart exactly on the final tick edge
        step(1'b1, 2'b10, 1'b0, 2'b00, 0);
        idle(7);
        step(1'b1, 2'b01, 1'b0, 2'b00, 0);
        idle(16);
        // Program and start together, sel=11 ignored
        step(1'b1, 2'b00, 1'b1, 2'b00, 9);
        idle(28);
        step(1'b1, 2'b00, 1'b1, 2'b11, 1);
        idle(40);
        // Reset mid-run, then interval=11 loads base
        step(1'b1, 2'b00, 1'b0, 2'b00, 0);
        idle(9);
        do_reset();
        idle(30);
        step(1'b1, 2'b11, 1'b0, 2'b00, 0);
        idle(28);

        for (int n = 0; n < 80; n++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                do_reset();
            end else if (r < 8) begin
                step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 2'b00, 0);
            end else if (r < 13) begin
                step(1'b0, 2'b00, 1'b1, 2'($urandom_range(0, 3)), $urandom_range(0, 15));
            end else if (r < 15) begin
                step(1'b1, 2'($urandom_range(0, 3)), 1'b1, 2'($urandom_range(0, 3)),
                     $urandom_range(0, 15));
            end
            idle($urandom_range(0, 40));
        end
        idle(70);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
